// File: rtl/lemming_pkg.sv
// rtl/lemming_pkg.sv - shared state encoding, constants and output decode for the lemming FSM
package lemming_pkg;

   // Longest fall (in clock cycles) a lemming survives unless overridden
   localparam int DEFAULT_SPLAT_CYCLES = 20;

   // Fall counter width; holds up to SPLAT_CYCLES+1 for the legal range 1..62
   localparam int FALL_CNT_W = 6;

   // SPLAT is only ever entered when the splat feature is compiled in
   typedef enum logic [2:0] {
      WL    = 3'd0,
      WR    = 3'd1,
      FL    = 3'd2,
      FR    = 3'd3,
      DL    = 3'd4,
      DR    = 3'd5,
      SPLAT = 3'd6
   } lemming_state_t;

   // One-hot motion outputs; all zero only in SPLAT
   typedef struct packed {
      logic walk_left;
      logic walk_right;
      logic aaah;
      logic digging;
   } lemming_motion_t;

   // Moore decode of the motion outputs from a state
   function automatic lemming_motion_t decode_motion(input lemming_state_t s);
      lemming_motion_t m;
      m = '0;
      case (s)
         WL:      m.walk_left  = 1'b1;
         WR:      m.walk_right = 1'b1;
         FL, FR:  m.aaah       = 1'b1;
         DL, DR:  m.digging    = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

   // True while the lemming is in free fall
   function automatic logic is_falling(input lemming_state_t s);
      return (s == FL) || (s == FR);
   endfunction

endpackage

// File: rtl/lemming_fsm_fall_timer.sv
// rtl/lemming_fsm_fall_timer.sv - saturating fall-length counter with over-limit flag
module fall_timer
   import lemming_pkg::*;
#(
   parameter int SPLAT_CYCLES = DEFAULT_SPLAT_CYCLES
)
(
   input  logic clk,
   input  logic areset,
   input  logic falling,
   output logic over_limit
);

   localparam logic [FALL_CNT_W-1:0] CNT_MAX   = FALL_CNT_W'(SPLAT_CYCLES + 1);
   localparam logic [FALL_CNT_W-1:0] CNT_LIMIT = FALL_CNT_W'(SPLAT_CYCLES);

   // cnt_q holds the number of fall cycles already completed, so the
   // fall cycle in progress is cnt_q + 1 (first aaah cycle is cycle 1).
   logic [FALL_CNT_W-1:0] cnt_q;
   logic [FALL_CNT_W-1:0] cnt_d;

   // Clear outside a fall, otherwise count up and stick at SPLAT_CYCLES+1
   always_comb begin
      cnt_d = cnt_q;
      if (!falling) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (areset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Current fall cycle (cnt_q + 1) exceeds SPLAT_CYCLES
   assign over_limit = falling && (cnt_q >= CNT_LIMIT);

endmodule

// File: rtl/lemming_fsm.sv
// rtl/lemming_fsm.sv - Moore lemming walker FSM; LEMMING_SPLAT_EN adds fatal-fall detection
module lemming_fsm
   import lemming_pkg::*;
#(
   parameter int SPLAT_CYCLES = DEFAULT_SPLAT_CYCLES
)
(
   input  logic clk,
   input  logic areset,
   input  logic bump_left,
   input  logic bump_right,
   input  logic ground,
   input  logic dig,
   output logic walk_left,
   output logic walk_right,
   output logic aaah,
   output logic digging
`ifdef LEMMING_SPLAT_EN
   ,
   output logic splat
`endif
);

   // Reject out-of-range fall limits at elaboration
   if ((SPLAT_CYCLES < 1) || (SPLAT_CYCLES > 62)) begin : g_bad_splat_cycles
      $error("lemming_fsm: SPLAT_CYCLES must be within 1..62");
   end

   lemming_state_t  state_q;
   lemming_state_t  state_d;
   lemming_motion_t motion_q;

`ifdef LEMMING_SPLAT_EN
   logic falling;
   logic over_limit;
   logic splat_q;

   assign falling = is_falling(state_q);

   fall_timer #(
      .SPLAT_CYCLES (SPLAT_CYCLES)
   ) u_fall_timer (
      .clk        (clk),
      .areset     (areset),
      .falling    (falling),
      .over_limit (over_limit)
   );
`endif

   // Next-state logic: falling beats digging beats bumping in the walk states
   always_comb begin
      state_d = state_q;
      case (state_q)
         WL: begin
            if (!ground) begin
               state_d = FL;
            end else if (dig) begin
               state_d = DL;
            end else if (bump_left) begin
               // covers the both-bumps case as well
               state_d = WR;
            end
         end
         WR: begin
            if (!ground) begin
               state_d = FR;
            end else if (dig) begin
               state_d = DR;
            end else if (bump_right) begin
               state_d = WL;
            end
         end
         DL: begin
            if (!ground) begin
               state_d = FL;
            end
         end
         DR: begin
            if (!ground) begin
               state_d = FR;
            end
         end
         FL: begin
            if (ground) begin
`ifdef LEMMING_SPLAT_EN
               state_d = over_limit ? SPLAT : WL;
`else
               state_d = WL;
`endif
            end
         end
         FR: begin
            if (ground) begin
`ifdef LEMMING_SPLAT_EN
               state_d = over_limit ? SPLAT : WR;
`else
               state_d = WR;
`endif
            end
         end
`ifdef LEMMING_SPLAT_EN
         SPLAT: begin
            // absorbing until reset
            state_d = SPLAT;
         end
`endif
         default: begin
            state_d = WL;
         end
      endcase
   end

   // State and registered Moore outputs; reset wins over every input
   always_ff @(posedge clk) begin
      if (areset) begin
         state_q  <= WL;
         motion_q <= decode_motion(WL);
`ifdef LEMMING_SPLAT_EN
         splat_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         motion_q <= decode_motion(state_d);
`ifdef LEMMING_SPLAT_EN
         splat_q  <= (state_d == SPLAT);
`endif
      end
   end

   assign walk_left  = motion_q.walk_left;
   assign walk_right = motion_q.walk_right;
   assign aaah       = motion_q.aaah;
   assign digging    = motion_q.digging;
`ifdef LEMMING_SPLAT_EN
   assign splat      = splat_q;
`endif

endmodule

// File: tb/tb_lemming_fsm.sv
// tb/tb_lemming_fsm.sv - directed self-checking bench for lemming_fsm (LEMMING_SPLAT_EN optional)
module tb_lemming_fsm;

   logic clk;
   logic areset;
   logic bump_left;
   logic bump_right;
   logic ground;
   logic dig;
   logic walk_left;
   logic walk_right;
   logic aaah;
   logic digging;
`ifdef LEMMING_SPLAT_EN
   logic splat;
`endif

   int tests_run;
   int tests_failed;

   logic [3:0] obs;
   assign obs = {walk_left, walk_right, aaah, digging};

   localparam logic [3:0] M_WL   = 4'b1000;
   localparam logic [3:0] M_WR   = 4'b0100;
   localparam logic [3:0] M_FALL = 4'b0010;
   localparam logic [3:0] M_DIG  = 4'b0001;
   localparam logic [3:0] M_NONE = 4'b0000;

   lemming_fsm dut (
      .clk        (clk),
      .areset     (areset),
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .ground     (ground),
      .dig        (dig),
      .walk_left  (walk_left),
      .walk_right (walk_right),
      .aaah       (aaah),
      .digging    (digging)
`ifdef LEMMING_SPLAT_EN
      ,
      .splat      (splat)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      areset     = 1'b0;
      bump_left  = 1'b0;
      bump_right = 1'b0;
      ground     = 1'b1;
      dig        = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      areset = 1'b1;
      step();
      areset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bump_left = 1'b1;
      ground    = 1'b0;
      areset    = 1'b1;
      step();
      tests_run++;
      if (obs !== M_WL) begin
         tests_failed++;
         $display("FAIL reset_outputs got=%b want=%b", obs, M_WL);
      end
`ifdef LEMMING_SPLAT_EN
      tests_run++;
      if (splat !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_splat got=%b want=0", splat);
      end
`endif
      idle_inputs();
   endtask

   task automatic test_bump();
      do_reset();
      bump_right = 1'b1;
      step();
      tests_run++;
      if (obs !== M_WL) begin
         tests_failed++;
         $display("FAIL bump_right_in_wl_holds got=%b want=%b", obs, M_WL);
      end
      bump_right = 1'b0;
      bump_left  = 1'b1;
      step();
      bump_left = 1'b0;
      tests_run++;
      if (obs !== M_WR) begin
         tests_failed++;
         $display("FAIL bump_left_turns_right got=%b want=%b", obs, M_WR);
      end
      step();
      tests_run++;
      if (obs !== M_WR) begin
         tests_failed++;
         $display("FAIL wr_holds got=%b want=%b", obs, M_WR);
      end
      bump_left  = 1'b1;
      bump_right = 1'b1;
      step();
      tests_run++;
      if (obs !== M_WL) begin
         tests_failed++;
         $display("FAIL both_bumps_in_wr got=%b want=%b", obs, M_WL);
      end
      step();
      tests_run++;
      if (obs !== M_WR) begin
         tests_failed++;
         $display("FAIL both_bumps_in_wl got=%b want=%b", obs, M_WR);
      end
      idle_inputs();
   endtask

   task automatic test_fall_right();
      do_reset();
      bump_left = 1'b1;
      step();
      bump_left = 1'b0;
      ground    = 1'b0;
      dig       = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         bump_left  = i[0];
         bump_right = ~i[0];
         step();
         tests_run++;
         if (obs !== M_FALL) begin
            tests_failed++;
            $display("FAIL fall_right_cycle%0d got=%b want=%b", i, obs, M_FALL);
         end
      end
      bump_left  = 1'b0;
      bump_right = 1'b0;
      ground     = 1'b1;
      step();
      tests_run++;
      if (obs !== M_WR) begin
         tests_failed++;
         $display("FAIL land_right got=%b want=%b", obs, M_WR);
      end
      step();
      tests_run++;
      if (obs !== M_DIG) begin
         tests_failed++;
         $display("FAIL dig_after_landing got=%b want=%b", obs, M_DIG);
      end
      idle_inputs();
   endtask

   task automatic test_dig();
      do_reset();
      dig = 1'b1;
      step();
      tests_run++;
      if (obs !== M_DIG) begin
         tests_failed++;
         $display("FAIL dig_start got=%b want=%b", obs, M_DIG);
      end
      dig       = 1'b0;
      bump_left = 1'b1;
      step();
      bump_left = 1'b0;
      tests_run++;
      if (obs !== M_DIG) begin
         tests_failed++;
         $display("FAIL dig_ignores_bump got=%b want=%b", obs, M_DIG);
      end
      ground = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         tests_run++;
         if (obs !== M_FALL) begin
            tests_failed++;
            $display("FAIL dig_fall_cycle%0d got=%b want=%b", i, obs, M_FALL);
         end
      end
      ground = 1'b1;
      step();
      tests_run++;
      if (obs !== M_WL) begin
         tests_failed++;
         $display("FAIL dig_land_left got=%b want=%b", obs, M_WL);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_fall();
      do_reset();
      ground = 1'b0;
      for (int i = 0; i < 15; i++) step();
      tests_run++;
      if (obs !== M_FALL) begin
         tests_failed++;
         $display("FAIL fall_cycle15 got=%b want=%b", obs, M_FALL);
      end
      areset = 1'b1;
      step();
      areset = 1'b0;
      tests_run++;
      if (obs !== M_WL) begin
         tests_failed++;
         $display("FAIL reset_mid_fall got=%b want=%b", obs, M_WL);
      end
      for (int i = 0; i < 20; i++) step();
      ground = 1'b1;
      step();
      tests_run++;
      if (obs !== M_WL) begin
         tests_failed++;
         $display("FAIL fall20_after_reset got=%b want=%b", obs, M_WL);
      end
`ifdef LEMMING_SPLAT_EN
      tests_run++;
      if (splat !== 1'b0) begin
         tests_failed++;
         $display("FAIL fall20_after_reset_splat got=%b want=0", splat);
      end
`endif
      idle_inputs();
   endtask

`ifdef LEMMING_SPLAT_EN
   task automatic test_splat_boundary();
      do_reset();
      ground = 1'b0;
      for (int i = 0; i < 20; i++) step();
      ground = 1'b1;
      step();
      tests_run++;
      if ({obs, splat} !== {M_WL, 1'b0}) begin
         tests_failed++;
         $display("FAIL fall20_survives got=%b want=%b", {obs, splat}, {M_WL, 1'b0});
      end
      ground = 1'b0;
      for (int i = 0; i < 21; i++) step();
      ground = 1'b1;
      step();
      tests_run++;
      if ({obs, splat} !== {M_NONE, 1'b1}) begin
         tests_failed++;
         $display("FAIL fall21_splats got=%b want=%b", {obs, splat}, {M_NONE, 1'b1});
      end
      for (int i = 0; i < 100; i++) begin
         bump_left  = 1'($urandom);
         bump_right = 1'($urandom);
         ground     = 1'($urandom);
         dig        = 1'($urandom);
         step();
         tests_run++;
         if ({obs, splat} !== {M_NONE, 1'b1}) begin
            tests_failed++;
            $display("FAIL splat_hold_cycle%0d got=%b want=%b", i, {obs, splat}, {M_NONE, 1'b1});
         end
      end
      idle_inputs();
      areset = 1'b1;
      step();
      areset = 1'b0;
      tests_run++;
      if ({obs, splat} !== {M_WL, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_from_splat got=%b want=%b", {obs, splat}, {M_WL, 1'b0});
      end
   endtask
`else
   task automatic test_long_fall();
      do_reset();
      bump_left = 1'b1;
      step();
      bump_left = 1'b0;
      ground    = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         step();
         tests_run++;
         if (obs !== M_FALL) begin
            tests_failed++;
            $display("FAIL long_fall_cycle%0d got=%b want=%b", i, obs, M_FALL);
         end
      end
      ground = 1'b1;
      step();
      tests_run++;
      if (obs !== M_WR) begin
         tests_failed++;
         $display("FAIL long_fall_land got=%b want=%b", obs, M_WR);
      end
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      idle_inputs();
      test_reset();
      test_bump();
      test_fall_right();
      test_dig();
      test_reset_mid_fall();
`ifdef LEMMING_SPLAT_EN
      test_splat_boundary();
`else
      test_long_fall();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
